rgb_pixel_packer: RTL and testbench
===================================

# rgb_pixel_packer

Upstream feeder for the 16-lane `rgb_ycbcr` converter. It accepts one RGB888 pixel per cycle over a valid/ready handshake and packs 16 pixels into a 384-bit block. It launches the block with a one-cycle `start` pulse and stalls the pixel source until the converter reports completion on `all_end`. It keeps the converter's input word stable for the whole conversion and counts launched blocks.

## Interface
Parameters:
- `LANES`, 16: pixels per block; must equal the converter lane count.
- `PIX_W`, 24: bits per pixel, RGB888 with R in [23:16], G in [15:8], B in [7:0].

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `pix_in`, input, PIX_W: incoming pixel.
- `pix_valid`, input, 1: `pix_in` is valid this cycle.
- `pix_ready`, output, 1: the packer accepts a pixel this cycle.
- `pix_last`, input, 1: the accepted pixel is the last of its frame; used only when `RGB_PACK_FLUSH_EN` is defined.
- `all_end`, input, 1: completion level from the converter.
- `start`, output, 1: one-cycle launch pulse to the converter.
- `d_out`, output, LANES*PIX_W: packed block, wired to the converter's `d_in`.
- `busy`, output, 1: a block is launched and not yet completed.
- `blk_cnt`, output, 16: number of blocks launched since reset; wraps 0xFFFF to 0.

## Operation
- A pixel is accepted when `pix_valid && pix_ready` at a rising edge.
- Lane index `lane`, 4 bits, starts at 0. The first accepted pixel goes to `d_out[23:0]`; the pixel at lane k goes to bits [24k+23:24k]. The 16th pixel goes to [383:360].
- Pixels are packed into an internal shadow register. `d_out` is loaded from the shadow register only on the FILL→LAUNCH transition, so `d_out` never changes while the converter is working.
- States:
  - FILL: `pix_ready`=1. On acceptance, write the lane and increment `lane`. If `lane`==15 on acceptance, go to LAUNCH and reset `lane` to 0.
  - LAUNCH: lasts exactly one cycle. `start`=1, `pix_ready`=0, `busy`=1. `blk_cnt` increments. Next state is WAIT.
  - WAIT: `pix_ready`=0, `busy`=1. Stay here until a rising edge of `all_end` is detected (current value 1, registered previous value 0), then return to FILL.
- Because completion is edge-detected, an `all_end` level left over from the previous block does not end WAIT early.
- `all_end` activity while in FILL or LAUNCH is ignored, apart from updating the edge-detect register.
- `pix_valid` is ignored whenever `pix_ready`=0, and no pixel is lost. The source must hold the pixel until it is accepted.

## Timing
- Reset values: `pix_ready`=0 while `rst_n`=0 and 1 in the first cycle after release (state FILL). `start`=0, `busy`=0, `d_out`=0, `blk_cnt`=0, `lane`=0, shadow register=0, edge-detect register=0.
- `pix_ready`, `start` and `busy` are decoded from the registered state, not combinationally from inputs.
- Latency:
  - The 16th pixel accepted at edge N sets `start`=1 and the new `d_out` in cycle N+1.
  - A rising edge of `all_end` sampled at edge M gives `pix_ready`=1 in cycle M+1.
- Minimum block period with a converter completing in C cycles: 16 + 1 + C + 1 cycles.
- Asserting reset mid-operation, in any state, immediately clears all state. Any partially filled block is discarded and `start` drops at once.

## Configuration
- `RGB_PACK_FLUSH_EN` defined:
  - An accepted pixel with `pix_last`=1 closes the block early. Lanes above the current index are zero-filled, the packer goes to LAUNCH, and `lane` resets to 0.
  - `pix_last` on lane 15 behaves like a normal full block.
- `RGB_PACK_FLUSH_EN` undefined: `pix_last` is ignored and a block launches only after 16 pixels.

## Test plan
- Full block: after reset, feed pixels 0x000001..0x000010 back-to-back with `pix_valid`=1.
  - Expect one `start` pulse in the cycle after the 16th accept.
  - Expect `d_out[23:0]`=0x000001, `d_out[383:360]`=0x000010, `blk_cnt`=1.
- Stall: hold `all_end`=0 for 40 cycles after `start` while `pix_valid` stays 1.
  - Expect `pix_ready`=0 and `d_out` unchanged for all 40 cycles, and no pixel consumed.
  - Raise `all_end`; expect `pix_ready`=1 on the next cycle.
- Stale completion: keep `all_end`=1 from the previous block through the next LAUNCH.
  - Expect the packer to stay in WAIT until `all_end` goes 0→1.
- Gapped source: toggle `pix_valid` 1/0 each cycle.
  - Expect 16 accepts across 31 cycles and a single correctly ordered block.
- Flush (macro defined): send 5 pixels 0xAABBCC with `pix_last`=1 on the 5th.
  - Expect lanes 0–4 = 0xAABBCC and lanes 5–15 = 0.
  - Without the macro, the same stimulus produces no `start`.
- Reset mid-fill: deassert `rst_n` after 7 pixels, then release and send 16 new pixels.
  - Expect the block to contain only the new pixels, with `blk_cnt`=1.

Source files
------------

// File: rtl/rgb_pixel_packer.sv
// ============================================================================
//  Module   : rgb_pixel_packer
//  Purpose  : Packs LANES RGB888 pixels, received over a valid/ready
//             handshake, into one LANES*PIX_W block for the rgb_ycbcr
//             converter. Launches each block with a one-cycle start pulse,
//             then holds the source off until the converter's all_end level
//             rises. The converter input word (d_out) only changes at launch.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    pix_in     in   PIX_W  pixel, R[23:16] G[15:8] B[7:0]
//    pix_valid  in   pix_in valid
//    pix_ready  out  packer accepts a pixel this cycle
//    pix_last   in   last pixel of frame (flush build only)
//    all_end    in   completion level from converter
//    start      out  one-cycle launch pulse
//    d_out      out  LANES*PIX_W packed block (lane k at [PIX_W*k +: PIX_W])
//    busy       out  block launched and not yet completed
//    blk_cnt    out  16-bit count of launched blocks, wraps
//  Build option
//    RGB_PACK_FLUSH_EN : when defined, pix_last closes a block early and the
//                        unused upper lanes are zero.
// ============================================================================
`default_nettype none

module rgb_pixel_packer #(
    parameter int LANES = 16,
    parameter int PIX_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic                   pix_last,
    input  logic                   all_end,
    output logic                   start,
    output logic [LANES*PIX_W-1:0] d_out,
    output logic                   busy,
    output logic [15:0]            blk_cnt
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [LANE_W-1:0]      lane;
    logic [LANES*PIX_W-1:0] shadow;
    logic [LANES*PIX_W-1:0] merged;
    logic                   all_end_q;
    logic                   accept;
    logic                   block_done;
    logic                   all_end_rise;

    assign accept       = pix_valid && pix_ready;
    assign all_end_rise = all_end && !all_end_q;

`ifdef RGB_PACK_FLUSH_EN
    assign block_done = accept && ((lane == LAST_LANE) || pix_last);
`else
    assign block_done = accept && (lane == LAST_LANE);
    logic unused_pix_last;
    assign unused_pix_last = pix_last;
`endif

    // Shadow with the incoming pixel dropped into the current lane; this is
    // what gets stored on a normal accept and what d_out takes at launch.
    always_comb begin
        merged = shadow;
        merged[int'(lane)*PIX_W +: PIX_W] = pix_in;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL:   if (block_done) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_WAIT;
            // Edge detect: a level still high from the previous block
            // cannot end the wait.
            ST_WAIT:   if (all_end_rise) state_nxt = ST_FILL;
            default:   state_nxt = ST_FILL;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    // pix_ready is gated by rst_n so the source sees no ready during reset,
    // even though the reset state itself is FILL.
    always_comb begin
        pix_ready = 1'b0;
        start     = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_FILL:   pix_ready = rst_n;
            ST_LAUNCH: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            ST_WAIT:   busy = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane      <= '0;
            shadow    <= '0;
            d_out     <= '0;
            blk_cnt   <= '0;
            all_end_q <= 1'b0;
        end else begin
            all_end_q <= all_end;
            if (accept) begin
                if (block_done) begin
                    // Clearing the shadow here means a flushed block's
                    // unwritten upper lanes read as zero.
                    d_out   <= merged;
                    shadow  <= '0;
                    lane    <= '0;
                    blk_cnt <= blk_cnt + 16'd1;
                end else begin
                    shadow <= merged;
                    lane   <= lane + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rgb_pixel_packer.sv
`default_nettype none

module tb_rgb_pixel_packer;

    localparam int LANES = 16;
    localparam int PIX_W = 24;
    localparam int BW    = LANES * PIX_W;

    typedef logic [PIX_W-1:0] pix_q_t[$];

    logic          clk = 1'b0;
    logic          rst_n;
    logic [23:0]   pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_last;
    logic          all_end;
    logic          start;
    logic [BW-1:0] d_out;
    logic          busy;
    logic [15:0]   blk_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_blk = 0;

    always #5 clk = ~clk;

    rgb_pixel_packer #(.LANES(LANES), .PIX_W(PIX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .all_end   (all_end),
        .start     (start),
        .d_out     (d_out),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    // Reference: pixel i of a block sits at bits [24i+23:24i], rest zero.
    function automatic logic [BW-1:0] pack(input pix_q_t px);
        logic [BW-1:0] r = '0;
        for (int i = 0; i < px.size(); i++)
            r = r | ({{(BW-PIX_W){1'b0}}, px[i]} << (PIX_W * i));
        return r;
    endfunction

    function automatic pix_q_t rand_pixels(input int n);
        pix_q_t q;
        for (int i = 0; i < n; i++) q.push_back(24'($urandom));
        return q;
    endfunction

    // Present one pixel and hold it until accepted (bounded wait).
    task automatic feed(input logic [23:0] p, input logic last, output bit ok, output time t_acc);
        int waited = 0;
        ok = 1'b0;
        t_acc = 0;
        @(negedge clk);
        pix_in = p; pix_valid = 1'b1; pix_last = last;
        #1;
        while (!pix_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (pix_ready) begin
            @(posedge clk);
            ok = 1'b1;
            t_acc = $time;
        end
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle between pixels,
    // 2 random 0..2 idle cycles with random all_end activity.
    task automatic send_pixels(input pix_q_t px, input int gap_mode, input logic last_on_end,
                               output int n_ok, output int cycles);
        time t0 = 0, t1 = 0, t;
        bit  ok;
        int  gap;
        n_ok = 0;
        for (int i = 0; i < px.size(); i++) begin
            gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (i > 0) begin
                repeat (gap) begin
                    @(negedge clk);
                    pix_valid = 1'b0; pix_last = 1'b0;
                    if (gap_mode == 2) all_end = 1'($urandom_range(0, 1));
                end
            end
            feed(px[i], last_on_end && (i == px.size() - 1), ok, t);
            if (ok) begin
                n_ok++;
                if (n_ok == 1) t0 = t;
                t1 = t;
            end
        end
        cycles = int'((t1 - t0) / 10) + 1;
    endtask

    // Lets the converter "finish": all_end low for c+1 cycles, then a rise.
    task automatic release_block(input int c);
        @(negedge clk);
        pix_valid = 1'b0; pix_last = 1'b0; all_end = 1'b0;
        repeat (c) @(negedge clk);
        @(negedge clk);
        all_end = 1'b1;
        @(negedge clk);
        all_end = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_last = 1'b0; all_end = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({pix_ready, start, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready/start/busy=%b, expected 000", {pix_ready, start, busy});
        end
        n_tests++;
        if (d_out !== '0 || blk_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: got blk_cnt=%h d_out_lo=%h, expected 0", blk_cnt, d_out[47:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b busy=%b, expected 1 0", pix_ready, busy);
        end
        exp_blk = 0;
    endtask

    task automatic test_full_block_and_stall();
        pix_q_t        px;
        logic [BW-1:0] exp;
        int            n_ok, cyc, bad;
        for (int i = 1; i <= 16; i++) px.push_back(24'(i));
        exp = pack(px);
        send_pixels(px, 0, 1'b0, n_ok, cyc);
        n_tests++;
        if (n_ok != 16 || cyc != 16) begin
            n_fail++;
            $display("FAIL full_accepts: got %0d accepts over %0d cycles, expected 16 over 16", n_ok, cyc);
        end
        @(negedge clk);
        pix_in = 24'h123456; pix_valid = 1'b1; pix_last = 1'b0;
        #1;
        exp_blk++;
        n_tests++;
        if (start !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_start: got start=%b busy=%b, expected 1 1", start, busy);
        end
        n_tests++;
        if (d_out !== exp) begin
            n_fail++;
            $display("FAIL full_dout: got lane0=%h lane15=%h, expected %h %h", d_out[23:0], d_out[383:360], exp[23:0], exp[383:360]);
        end
        n_tests++;
        if (blk_cnt !== 16'(exp_blk)) begin
            n_fail++;
            $display("FAIL full_blkcnt: got %0d, expected %0d", blk_cnt, exp_blk);
        end
        // 40 cycles of stall with the source pushing.
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (pix_ready !== 1'b0 || start !== 1'b0 || busy !== 1'b1 || d_out !== exp) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d bad stall cycles, expected 0", bad);
        end
        @(negedge clk);
        all_end = 1'b1; pix_valid = 1'b0;
        #1;
        n_tests++;
        if (pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_comb: got ready=%b before edge, expected 0", pix_ready);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_resume: got ready=%b busy=%b, expected 1 0", pix_ready, busy);
        end
        all_end = 1'b0;
    endtask

    task automatic test_stale_completion();
        pix_q_t px = rand_pixels(16);
        int     n_ok, cyc, bad;
        @(negedge clk);
        all_end = 1'b1;
        send_pixels(px, 0, 1'b0, n_ok, cyc);
        @(negedge clk);
        pix_valid = 1'b0;
        #1;
        exp_blk++;
        n_tests++;
        if (start !== 1'b1 || d_out !== pack(px)) begin
            n_fail++;
            $display("FAIL stale_launch: got start=%b lane0=%h, expected 1 %h", start, d_out[23:0], px[0]);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (pix_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stale_wait: got %0d cycles out of WAIT, expected 0", bad);
        end
        all_end = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_fall: got ready=%b, expected 0", pix_ready);
        end
        all_end = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_rise: got ready=%b, expected 1", pix_ready);
        end
        all_end = 1'b0;
    endtask

    task automatic test_gapped();
        pix_q_t px = rand_pixels(16);
        int     n_ok, cyc;
        send_pixels(px, 1, 1'b0, n_ok, cyc);
        n_tests++;
        if (n_ok != 16 || cyc != 31) begin
            n_fail++;
            $display("FAIL gapped_accepts: got %0d accepts over %0d cycles, expected 16 over 31", n_ok, cyc);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        #1;
        exp_blk++;
        n_tests++;
        if (start !== 1'b1 || d_out !== pack(px) || blk_cnt !== 16'(exp_blk)) begin
            n_fail++;
            $display("FAIL gapped_block: got start=%b cnt=%0d lane0=%h, expected 1 %0d %h", start, blk_cnt, d_out[23:0], exp_blk, px[0]);
        end
        release_block(5);
    endtask

    task automatic test_flush();
        pix_q_t px;
        int     n_ok, cyc, starts;
        for (int i = 0; i < 5; i++) px.push_back(24'hAABBCC);
        send_pixels(px, 0, 1'b1, n_ok, cyc);
`ifdef RGB_PACK_FLUSH_EN
        @(negedge clk);
        pix_valid = 1'b0; pix_last = 1'b0;
        #1;
        exp_blk++;
        n_tests++;
        if (start !== 1'b1 || d_out !== pack(px) || blk_cnt !== 16'(exp_blk)) begin
            n_fail++;
            $display("FAIL flush_block: got start=%b cnt=%0d lane4=%h lane5=%h, expected 1 %0d aabbcc 0", start, blk_cnt, d_out[119:96], d_out[143:120]);
        end
        release_block(3);
        // Lane index must restart at 0 after a flush.
        px = rand_pixels(16);
        send_pixels(px, 0, 1'b0, n_ok, cyc);
        @(negedge clk);
        pix_valid = 1'b0;
        #1;
        exp_blk++;
        n_tests++;
        if (start !== 1'b1 || d_out !== pack(px)) begin
            n_fail++;
            $display("FAIL flush_next: got start=%b lane0=%h, expected 1 %h", start, d_out[23:0], px[0]);
        end
        release_block(2);
`else
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            pix_valid = 1'b0; pix_last = 1'b0;
            #1;
            if (start === 1'b1 || pix_ready !== 1'b1) starts++;
        end
        n_tests++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL noflush_idle: got %0d cycles with start or no ready, expected 0", starts);
        end
        for (int i = 0; i < 11; i++) px.push_back(24'($urandom));
        begin
            pix_q_t rest;
            for (int i = 5; i < 16; i++) rest.push_back(px[i]);
            send_pixels(rest, 0, 1'b0, n_ok, cyc);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        #1;
        exp_blk++;
        n_tests++;
        if (start !== 1'b1 || d_out !== pack(px) || blk_cnt !== 16'(exp_blk)) begin
            n_fail++;
            $display("FAIL noflush_block: got start=%b cnt=%0d lane15=%h, expected 1 %0d %h", start, blk_cnt, d_out[383:360], exp_blk, px[15]);
        end
        release_block(2);
`endif
    endtask

    task automatic test_reset_mid_fill();
        pix_q_t px = rand_pixels(7);
        int     n_ok, cyc;
        send_pixels(px, 0, 1'b0, n_ok, cyc);
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({pix_ready, start, busy} !== 3'b000 || blk_cnt !== 16'd0 || d_out !== '0) begin
            n_fail++;
            $display("FAIL midfill_reset: got ctrl=%b cnt=%0d, expected 000 0", {pix_ready, start, busy}, blk_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_blk = 0;
        px = rand_pixels(16);
        send_pixels(px, 0, 1'b0, n_ok, cyc);
        @(negedge clk);
        pix_valid = 1'b0;
        #1;
        exp_blk++;
        n_tests++;
        if (start !== 1'b1 || d_out !== pack(px) || blk_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL midfill_block: got start=%b cnt=%0d lane0=%h, expected 1 1 %h", start, blk_cnt, d_out[23:0], px[0]);
        end
        // Reset during the launch cycle: start must drop immediately.
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (start !== 1'b0 || busy !== 1'b0 || blk_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL launch_reset: got start=%b busy=%b cnt=%0d, expected 0 0 0", start, busy, blk_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_blk = 0;
    endtask

    task automatic test_random_blocks();
        pix_q_t px;
        int     n_ok, cyc;
        for (int b = 0; b < 6; b++) begin
            px = rand_pixels(16);
            send_pixels(px, 2, 1'b0, n_ok, cyc);
            @(negedge clk);
            pix_valid = 1'b0;
            #1;
            exp_blk++;
            n_tests++;
            if (n_ok != 16 || start !== 1'b1 || d_out !== pack(px) || blk_cnt !== 16'(exp_blk)) begin
                n_fail++;
                $display("FAIL random_block%0d: got acc=%0d start=%b cnt=%0d lane7=%h, expected 16 1 %0d %h", b, n_ok, start, blk_cnt, d_out[191:168], exp_blk, px[7]);
            end
            release_block(int'($urandom_range(0, 8)));
            #1;
            n_tests++;
            if (pix_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL random_resume%0d: got ready=%b busy=%b, expected 1 0", b, pix_ready, busy);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_block_and_stall();
        test_stale_completion();
        test_gapped();
        test_flush();
        test_reset_mid_fill();
        test_random_blocks();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
